// File: rtl/sdram_threshold_engine.sv
// Chunk-buffered SDRAM threshold engine: reads pixels over Avalon-MM, binarises, writes back.
// Optional build macro SDRAM_THRESH_CHECKSUM_EN adds a checksum port summing the raw source pixels.
module sdram_threshold_engine #(
  parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
  parameter logic [31:0] DST_BASE  = 32'h0010_0000,
  parameter int          NUM_WORDS = 1024,
  parameter int          CHUNK     = 16
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic        start,
  input  logic [9:0]  threshold,
  output logic        done,
  output logic        busy,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
`ifdef SDRAM_THRESH_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int LW        = $clog2(CHUNK + 1);
  localparam int IW        = $clog2(CHUNK);
  localparam int RW        = $clog2(NUM_WORDS + 1);
  localparam int FIRST_LEN = (NUM_WORDS < CHUNK) ? NUM_WORDS : CHUNK;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t          state, state_next;
  logic            start_q, launch;
  logic [9:0]      thr;
  logic [31:0]     src, dst;
  logic [RW-1:0]   remain;
  logic [LW-1:0]   len, issued, rcv, widx;
  logic [LW-1:0]   issued_nxt, widx_nxt;
  logic [15:0]     mem [CHUNK];
  logic            rd_acc, wr_acc, rd_fill, read_done, write_done;
  logic [LW-1:0]   next_len;

  function automatic logic [15:0] binarise(input logic [15:0] p, input logic [9:0] t);
    return (p[15:6] >= t) ? 16'hFFFF : 16'h0000;
  endfunction

  assign rd_acc     = avm_read  & ~avm_waitrequest;
  assign wr_acc     = avm_write & ~avm_waitrequest;
  assign issued_nxt = issued + LW'(1);
  assign widx_nxt   = widx + LW'(1);
  // Responses beyond the chunk length (or outside READ) are discarded.
  assign rd_fill    = (state == READ) && avm_readdatavalid && (rcv != len);
  assign read_done  = (state == READ) && (rcv == len) && (issued == len);
  assign write_done = (state == WRITE) && (widx == len);
  assign next_len   = (32'(remain) >= 32'(CHUNK)) ? LW'(CHUNK) : LW'(remain);

  assign busy = (state == READ) || (state == WRITE);
  assign done = (state == DONE);

  always_ff @(posedge clock_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch)     state_next = READ;
      READ:    if (read_done)  state_next = WRITE;
      WRITE:   if (write_done) state_next = (remain == '0) ? DONE : READ;
      DONE:    if (!start)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Chunk buffer, no reset needed: every word is written before it is read.
  always_ff @(posedge clock_clk) begin
    if (!reset_reset && rd_fill) mem[rcv[IW-1:0]] <= avm_readdata;
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      start_q       <= 1'b1;
      launch        <= 1'b0;
      thr           <= '0;
      src           <= '0;
      dst           <= '0;
      remain        <= '0;
      len           <= '0;
      issued        <= '0;
      rcv           <= '0;
      widx          <= '0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
`ifdef SDRAM_THRESH_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      start_q <= start;
      launch  <= start & ~start_q;
      case (state)
        IDLE: begin
          if (launch) begin
            thr    <= threshold;
            src    <= SRC_BASE;
            dst    <= DST_BASE;
            remain <= RW'(NUM_WORDS);
            len    <= LW'(FIRST_LEN);
            issued <= '0;
            rcv    <= '0;
            widx   <= '0;
`ifdef SDRAM_THRESH_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        READ: begin
          // Request stays registered so address is stable across waitrequest stalls.
          if (rd_acc) begin
            issued <= issued_nxt;
            src    <= src + 32'd2;
            if (issued_nxt == len) avm_read <= 1'b0;
            else                   avm_address <= src + 32'd2;
          end else if (!avm_read && (issued != len)) begin
            avm_read    <= 1'b1;
            avm_address <= src;
          end
          if (rd_fill) begin
            rcv <= rcv + LW'(1);
`ifdef SDRAM_THRESH_CHECKSUM_EN
            checksum <= checksum + 32'(avm_readdata);
`endif
          end
        end
        WRITE: begin
          if (wr_acc) begin
            widx <= widx_nxt;
            dst  <= dst + 32'd2;
            if (widx_nxt == len) begin
              avm_write <= 1'b0;
              remain    <= remain - RW'(len);
            end else begin
              avm_address   <= dst + 32'd2;
              avm_writedata <= binarise(mem[widx_nxt[IW-1:0]], thr);
            end
          end else if (!avm_write && (widx != len)) begin
            avm_write     <= 1'b1;
            avm_address   <= dst;
            avm_writedata <= binarise(mem[widx[IW-1:0]], thr);
          end
          if (write_done && (remain != '0)) begin
            len    <= next_len;
            issued <= '0;
            rcv    <= '0;
            widx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_threshold_engine.sv
// Self-checking bench for sdram_threshold_engine: SDRAM slave model with random stalls and
// read latency, transaction logs, and a pixel-level reference model.
module tb_sdram_threshold_engine;
  localparam int          NW  = 37;
  localparam int          CH  = 16;
  localparam logic [31:0] SRC = 32'h0000_1000;
  localparam logic [31:0] DST = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  threshold;
  logic        done, busy;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [15:0] avm_writedata, avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;
`ifdef SDRAM_THRESH_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  sdram_threshold_engine #(
    .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW), .CHUNK(CH)
  ) dut (
    .clock_clk(clk), .reset_reset(rst), .start(start), .threshold(threshold),
    .done(done), .busy(busy), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
`ifdef SDRAM_THRESH_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int other_cnt; } rd_rec_t;
  typedef struct { logic [31:0] addr; logic [15:0] data; int other_cnt; } wr_rec_t;
  typedef struct { logic [15:0] data; int due; } resp_t;
  typedef struct { logic [15:0] pix; logic [15:0] exp; } vec_t;

  int          checks = 0, errors = 0;
  logic [15:0] src_mem [NW];
  rd_rec_t     rd_log[$];
  wr_rec_t     wr_log[$];
  resp_t       rq[$];
  int          cyc = 0, last_due = 0, done_rises = 0;
  logic        done_d = 1'b0;
  bit          rand_wait = 0, rand_lat = 0, inject = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input logic [15:0] p, input logic [9:0] t);
    return ((int'(p) / 64) >= int'(t)) ? 16'hFFFF : 16'h0000;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Slave: accept requests on the clock edge, log them, queue read data in order.
  always @(posedge clk) begin
    logic [31:0] off;
    int          lat, due;
    cyc++;
    if (!rst) begin
      if (avm_read && !avm_waitrequest) begin
        rd_log.push_back('{avm_address, wr_log.size()});
        off = avm_address - SRC;
        lat = rand_lat ? int'($urandom_range(1, 6)) : 1;
        due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = due;
        rq.push_back('{(off < 32'(2 * NW)) ? src_mem[int'(off >> 1)] : 16'hDEAD, due});
      end
      if (avm_write && !avm_waitrequest)
        wr_log.push_back('{avm_address, avm_writedata, rd_log.size()});
    end
  end

  always @(negedge clk) begin
    avm_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
    if (inject) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 16'(($urandom));
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = rq[0].data;
      void'(rq.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 16'h0000;
    end
  end

  always @(posedge clk) begin
    if (done && !done_d) done_rises++;
    done_d = done;
  end

  task automatic wait_done();
    for (int k = 0; k < 6000 && !done; k++) @(negedge clk);
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  // Launch a job with a fresh edge, check launch latency, optionally disturb it mid-job.
  task automatic run_job(input logic [9:0] thr, input bit perturb,
                         output int rb, output int wb);
    int dr;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rb = rd_log.size(); wb = wr_log.size(); dr = done_rises;
    threshold = thr;
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("lat_no_read_yet", {31'd0, avm_read}, 32'd0);
    check("busy_after_launch", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("lat_first_read", {31'd0, avm_read}, 32'd1);
    if (perturb) begin
      repeat (30) @(negedge clk);
      start = 1'b0; threshold = 10'd0;
      @(negedge clk);
      start = 1'b1;
      repeat (20) @(negedge clk);
      check("busy_after_restart_edge", {31'd0, busy}, 32'd1);
    end
    wait_done();
    check("busy_at_done", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("done_holds", {31'd0, done}, 32'd1);
    check("done_once", 32'(done_rises - dr), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_clears", {31'd0, done}, 32'd0);
  endtask

  // Compare logged traffic of one job against the reference model.
  task automatic verify_job(input int rb, input int wb, input logic [9:0] thr);
    check("rd_count", 32'(rd_log.size() - rb), 32'(NW));
    check("wr_count", 32'(wr_log.size() - wb), 32'(NW));
    for (int i = 0; i < NW && rb + i < rd_log.size(); i++) begin
      check("rd_addr", rd_log[rb + i].addr, SRC + 32'(2 * i));
      check("rd_chunk_order", 32'(rd_log[rb + i].other_cnt - wb), 32'(CH * (i / CH)));
    end
    for (int i = 0; i < NW && wb + i < wr_log.size(); i++) begin
      check("wr_addr", wr_log[wb + i].addr, DST + 32'(2 * i));
      check("wr_data", {16'd0, wr_log[wb + i].data}, {16'd0, ref_pix(src_mem[i], thr)});
      check("wr_chunk_order", 32'(wr_log[wb + i].other_cnt - rb), 32'(imin(NW, CH * (i / CH + 1))));
    end
`ifdef SDRAM_THRESH_CHECKSUM_EN
    begin
      logic [31:0] sum = 32'd0;
      for (int i = 0; i < NW; i++) sum += 32'(src_mem[i]);
      check("checksum", checksum, sum);
    end
`endif
  endtask

  initial begin
    vec_t vt[8];
    int   rb, wb, w0;
    bit   saw_rd, saw_wr;
    logic [9:0] thr;

    vt[0] = '{16'h0000, 16'h0000}; vt[1] = '{16'hFFC0, 16'hFFFF};
    vt[2] = '{16'h8000, 16'hFFFF}; vt[3] = '{16'h7FC0, 16'h0000};
    vt[4] = '{16'h7FFF, 16'h0000}; vt[5] = '{16'h803F, 16'hFFFF};
    vt[6] = '{16'hFFFF, 16'hFFFF}; vt[7] = '{16'h003F, 16'h0000};

    rst = 1'b1; start = 1'b0; threshold = 10'd0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_write", {31'd0, avm_write}, 32'd0);
    check("rst_addr", avm_address, 32'd0);
    check("rst_wdata", {16'd0, avm_writedata}, 32'd0);
`ifdef SDRAM_THRESH_CHECKSUM_EN
    check("rst_checksum", checksum, 32'd0);
`endif
    rst = 1'b0;

    // Table job: boundary pixels around threshold 0x200, remainder random.
    for (int i = 0; i < NW; i++) src_mem[i] = (i < 8) ? vt[i].pix : 16'($urandom);
    run_job(10'h200, 1'b0, rb, wb);
    for (int i = 0; i < 8; i++)
      check("table_vec", {16'd0, wr_log[wb + i].data}, {16'd0, vt[i].exp});
    verify_job(rb, wb, 10'h200);

    // Random stalls and read latency; partial final chunk.
    rand_wait = 1; rand_lat = 1;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NW; i++) src_mem[i] = 16'($urandom);
      thr = 10'($urandom);
      run_job(thr, 1'b0, rb, wb);
      verify_job(rb, wb, thr);
    end

    // Start held high through reset must not launch.
    @(negedge clk); start = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    saw_rd = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (avm_read || busy) saw_rd = 1;
    end
    check("no_launch_after_reset", {31'd0, saw_rd}, 32'd0);
    for (int i = 0; i < NW; i++) src_mem[i] = 16'($urandom);
    run_job(10'h155, 1'b0, rb, wb);
    verify_job(rb, wb, 10'h155);

    // Second edge and threshold change mid-job are ignored.
    for (int i = 0; i < NW; i++) src_mem[i] = 16'($urandom);
    run_job(10'h2A0, 1'b1, rb, wb);
    verify_job(rb, wb, 10'h2A0);

    // Reset during the writes of chunk 2, then stray read responses.
    start = 1'b0;
    repeat (2) @(negedge clk);
    wb = wr_log.size();
    threshold = 10'h100;
    start = 1'b1;
    for (int k = 0; k < 3000 && (wr_log.size() - wb) < CH + 3; k++) @(negedge clk);
    check("reached_chunk2_write", {31'd0, (wr_log.size() - wb) >= CH + 3}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_read", {31'd0, avm_read}, 32'd0);
    check("abort_write", {31'd0, avm_write}, 32'd0);
    check("abort_addr", avm_address, 32'd0);
    check("abort_wdata", {16'd0, avm_writedata}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0; inject = 1;
    repeat (4) @(negedge clk);
    inject = 0;
    w0 = wr_log.size(); saw_wr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (avm_write || avm_read || busy) saw_wr = 1;
    end
    check("idle_after_abort", {31'd0, saw_wr}, 32'd0);
    check("no_write_after_abort", 32'(wr_log.size() - w0), 32'd0);
    for (int i = 0; i < NW; i++) src_mem[i] = 16'hFFFF;
    run_job(10'h3FF, 1'b0, rb, wb);
    verify_job(rb, wb, 10'h3FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
